// File: rtl/bf16_mul_seq.sv
// Sequential bf16 multiplier: special operands retire in 1 cycle, normal operands
// take 8 shift-add cycles + 1 normalize/round cycle. in_ready is low until the result is taken.
module bf16_mul_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 7,
  parameter int BIAS       = 127
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int MW = FRAC_WIDTH + 1;
  localparam int PW = 2 * MW;
  localparam int CW = $clog2(MW);
  localparam int EW = EXP_WIDTH + 2;
  localparam logic signed [EW-1:0] EXP_MAX_S = EW'((1 << EXP_WIDTH) - 1);
  localparam logic signed [EW-1:0] BIAS_S    = EW'(BIAS);
  localparam logic signed [EW-1:0] ONE_S     = EW'(1);
  localparam logic signed [EW-1:0] ZERO_S    = '0;
  localparam logic [DATA_WIDTH-1:0] QNAN =
    {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          acc_q, acc_d;
  logic [MW-1:0]          mcand_q, mcand_d;
  logic [MW-1:0]          mplier_q, mplier_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic                   sign_q, sign_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;

  logic [EXP_WIDTH-1:0]   a_exp, b_exp;
  logic [FRAC_WIDTH-1:0]  a_frac, b_frac;
  logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, prod_sign;
  logic [FRAC_WIDTH-1:0]  n_frac;
  logic [FRAC_WIDTH:0]    n_rnd;
  logic                   n_guard, n_sticky;
  logic signed [EW-1:0]   n_exp;

  always_comb begin
    a_exp     = a[DATA_WIDTH-2 -: EXP_WIDTH];
    b_exp     = b[DATA_WIDTH-2 -: EXP_WIDTH];
    a_frac    = a[FRAC_WIDTH-1:0];
    b_frac    = b[FRAC_WIDTH-1:0];
    // Denormals are flushed: any zero exponent counts as zero.
    a_zero    = (a_exp == '0);
    b_zero    = (b_exp == '0);
    a_inf     = (a_exp == '1) && (a_frac == '0);
    b_inf     = (b_exp == '1) && (b_frac == '0);
    a_nan     = (a_exp == '1) && (a_frac != '0);
    b_nan     = (b_exp == '1) && (b_frac != '0);
    prod_sign = a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
  end

  always_comb begin
    n_exp = exp_q;
    if (acc_q[PW-1]) begin
      n_frac   = acc_q[PW-2 -: FRAC_WIDTH];
      n_guard  = acc_q[PW-2-FRAC_WIDTH];
      n_sticky = |acc_q[PW-3-FRAC_WIDTH:0];
      n_exp    = exp_q + ONE_S;
    end else begin
      n_frac   = acc_q[PW-3 -: FRAC_WIDTH];
      n_guard  = acc_q[PW-3-FRAC_WIDTH];
      n_sticky = |acc_q[PW-4-FRAC_WIDTH:0];
    end
    n_rnd = {1'b0, n_frac} + (FRAC_WIDTH+1)'(n_guard & (n_sticky | n_frac[0]));
    // Rounding carry-out leaves the low bits zero, so only the exponent moves.
    if (n_rnd[FRAC_WIDTH]) n_exp = n_exp + ONE_S;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d = prod_sign;
          if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            result_d = QNAN;
            state_d  = S_DONE;
          end else if (a_inf || b_inf) begin
            result_d = {prod_sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
            state_d  = S_DONE;
          end else if (a_zero || b_zero) begin
            result_d = {prod_sign, {(DATA_WIDTH-1){1'b0}}};
            state_d  = S_DONE;
          end else begin
            mcand_d  = {1'b1, a_frac};
            mplier_d = {1'b1, b_frac};
            acc_d    = '0;
            cnt_d    = '0;
            exp_d    = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS_S;
            state_d  = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (mplier_q[cnt_q]) acc_d = acc_q + (PW'(mcand_q) << cnt_q);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(MW-1)) state_d = S_NORM;
      end
      S_NORM: begin
        if (n_exp >= EXP_MAX_S)
          result_d = {sign_q, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
        else if (n_exp <= ZERO_S)
          result_d = {sign_q, {(DATA_WIDTH-1){1'b0}}};
        else
          result_d = {sign_q, n_exp[EXP_WIDTH-1:0], n_rnd[FRAC_WIDTH-1:0]};
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: doc/bf16_mul_seq.md
# bf16_mul_seq

Multi-cycle bfloat16 multiplier that sits directly downstream of the operand zero-detect stage. It accepts two bf16 operands over a valid/ready handshake and classifies them: zero, flushed denormal, infinity, NaN. Special cases retire on a one-cycle fast path. Normal operands go through an 8-cycle shift-add mantissa multiply, normalization and round-to-nearest-even, and the result is presented on a second valid/ready handshake.

## Interface
- DATA_WIDTH, 16, operand/result width
- EXP_WIDTH, 8, exponent field width
- FRAC_WIDTH, 7, stored fraction width
- BIAS, 127, exponent bias
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  operands a, b valid
- in_ready  output  1  block can accept operands
- a  input  DATA_WIDTH  operand A (bf16)
- b  input  DATA_WIDTH  operand B (bf16)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  DATA_WIDTH  bf16 product

## Operation
- States:
  - IDLE: in_ready=1.
  - MUL: 8 iterations.
  - NORM: 1 cycle.
  - DONE: out_valid=1.
- Accept occurs when in_valid & in_ready at a rising edge. a and b are captured at that edge.
- Operand classification on accept. exp=0 means the operand is zero; a nonzero fraction is a denormal and is flushed to zero. exp=all-ones with frac≠0 is NaN; with frac=0 it is Inf.
- Result sign is sign(a) XOR sign(b) for all non-NaN results.
- Fast path (IDLE→DONE) is taken when:
  - either operand is NaN → 0x7FC0;
  - Inf×zero → 0x7FC0;
  - Inf×nonzero → signed Inf;
  - zero×finite → signed zero.
- Normal path (IDLE→MUL):
  - Mantissas are {1,frac}, 8 bits each.
  - Exponent sum is ea+eb−BIAS, held in a 10-bit signed register.
  - The 3-bit counter is cleared on accept.
- MUL: each cycle examines one multiplier bit, LSB first, and conditionally adds the shifted multiplicand into a 16-bit accumulator. After count 7, go to NORM.
- NORM:
  - If product[15]=1: frac=product[14:8], guard=product[7], sticky=|product[6:0], exp+1.
  - Else: frac=product[13:7], guard=product[6], sticky=|product[5:0].
  - RNE: increment when guard & (sticky | frac[0]). A fraction carry-out increments exp and zeroes frac.
  - Final exp ≥ 255 → signed Inf (0x7F80/0xFF80).
  - Final exp ≤ 0 → signed zero; no denormal output.
  - Go to DONE.
- DONE: result is held stable while out_valid=1. Go to IDLE on out_ready. There is no accept in the same cycle, so throughput is one operation per (latency+1) cycles minimum.
- in_ready=0 in MUL, NORM and DONE. in_valid is ignored there and the operands are not captured.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0x0000, state=IDLE, counter=0, accumulator=0.
- Reset asserted in any state returns to IDLE on the next edge. Any in-flight operation is discarded and no out_valid is produced for it.
- Latency, counting the accept edge as cycle 0:
  - Fast path: out_valid=1 from cycle 1.
  - Normal path: MUL occupies cycles 1–8, NORM is cycle 9, out_valid=1 from cycle 10.
- out_valid, once high, stays high with result unchanged until the edge where out_ready=1. It drops the cycle after that edge, and in_ready rises the same cycle.
- out_ready asserted while out_valid=0 has no effect.
- in_ready is a registered state decode. It never depends combinationally on out_ready.

## Test plan
- 0x3F80 × 0x4000 (1.0×2.0), out_ready tied 1 → result 0x4000, out_valid exactly 10 cycles after accept, in_ready high the following cycle.
- 0x3FC1 × 0x3FC1 → 0x4012 (RNE rounds up, guard=1, sticky=1). Also 0x3FC0 × 0x3FC0 → 0x4010.
- Fast path with 1-cycle latency:
  - 0x8000 × 0x3F80 → 0x8000;
  - 0x0001 (denormal) × 0x4049 → 0x0000;
  - 0x7F80 × 0x0000 → 0x7FC0;
  - 0xFF80 × 0x4000 → 0xFF80;
  - 0x7FC1 × 0x3F80 → 0x7FC0.
- Overflow/underflow: 0x7F00 × 0x7F00 → 0x7F80; 0x0080 × 0x0080 → 0x0000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → result stable, in_ready=0, new in_valid ignored. Then raise out_ready → one transfer, then in_ready=1.
- Reset mid-MUL (cycle 4) → next cycle state IDLE, in_ready=1, out_valid=0. No stale result appears afterwards, and the next operation (0x3F80×0x3F80) returns 0x3F80.
